// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// codes, controller state encoding and datapath widths.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF     = 2'b00;
  localparam fwd_sel_t FWD_EXALU  = 2'b01;
  localparam fwd_sel_t FWD_MEMALU = 2'b10;
  localparam fwd_sel_t FWD_MEMLD  = 2'b11;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// Operand forward select for one ID-stage source register. EX wins over
// MEM; a load sitting in EX cannot forward (its data is not ready yet),
// which the stall logic in the parent covers.
module fwd_select_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] field,
  input  logic             use_f,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [REG_W-1:0] ex_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [REG_W-1:0] mem_rn,
  output fwd_sel_t         sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = use_f & ex_wreg  & ~ex_m2reg & (ex_rn  != '0) & (ex_rn  == field);
  assign mem_hit = use_f & mem_wreg &             (mem_rn != '0) & (mem_rn == field);

  // Priority select: EX ALU, then MEM (ALU or load data), then register file
  always_comb begin
    sel = FWD_RF;
    if (ex_hit)
      sel = FWD_EXALU;
    else if (mem_hit)
      sel = mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard controller for the 5-stage pipeline: load-use and
// HI/LO stalls, branch flush, operand forwarding and a stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_mdu_start,
  input  logic             id_use_hilo,
  input  logic             id_branch_taken,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [REG_W-1:0] ex_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [REG_W-1:0] mem_rn,
  output logic             wpcir,
  output logic             id_bubble,
  output logic             if_flush,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             mdu_busy,
  output logic [31:0]      stall_cycles
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      stall_cnt;
  fwd_sel_t         fwda_raw;
  fwd_sel_t         fwdb_raw;
  logic             load_use;
  logic             stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  fwd_select_unit u_fwd_rs (
    .field     (id_rs),
    .use_f     (id_use_rs),
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_rn     (ex_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .sel       (fwda_raw)
  );

  fwd_select_unit u_fwd_rt (
    .field     (id_rt),
    .use_f     (id_use_rt),
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_rn     (ex_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .sel       (fwdb_raw)
  );

  assign load_use = ex_wreg & ex_m2reg & (ex_rn != '0) &
                    ((id_use_rs & (ex_rn == id_rs)) | (id_use_rt & (ex_rn == id_rt)));
  assign stall    = load_use | ((state == ST_MDU_WAIT) & id_use_hilo);

  assign mdu_busy     = (state == ST_MDU_WAIT);
  assign stall_cycles = stall_cnt;

  // Hazard outputs; while in reset, force nops into the pipeline
  always_comb begin
    wpcir     = ~stall;
    id_bubble = stall;
    if_flush  = id_branch_taken & ~stall;
    fwda      = fwda_raw;
    fwdb      = fwdb_raw;
    if (!clrn) begin
      wpcir     = 1'b1;
      id_bubble = 1'b1;
      if_flush  = 1'b1;
      fwda      = FWD_RF;
      fwdb      = FWD_RF;
    end
  end

  // MDU tracking FSM and saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= ST_RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall)
        stall_cnt <= sat_inc(stall_cnt);
      case (state)
        ST_RUN: begin
          if (id_mdu_start && !load_use) begin
            state <= ST_MDU_WAIT;
            cnt   <= CNT_W'(MDU_LATENCY - 1);
          end
        end
        ST_MDU_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of combinational
// forwarding/stall vectors plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  id_rs, id_rt, ex_rn, mem_rn;
  logic        id_use_rs, id_use_rt, id_mdu_start, id_use_hilo, id_branch_taken;
  logic        ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic        wpcir, id_bubble, if_flush, mdu_busy;
  logic [1:0]  fwda, fwdb;
  logic [31:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(4)) dut (
    .clk             (clk),
    .clrn            (clrn),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_mdu_start    (id_mdu_start),
    .id_use_hilo     (id_use_hilo),
    .id_branch_taken (id_branch_taken),
    .ex_wreg         (ex_wreg),
    .ex_m2reg        (ex_m2reg),
    .ex_rn           (ex_rn),
    .mem_wreg        (mem_wreg),
    .mem_m2reg       (mem_m2reg),
    .mem_rn          (mem_rn),
    .wpcir           (wpcir),
    .id_bubble       (id_bubble),
    .if_flush        (if_flush),
    .fwda            (fwda),
    .fwdb            (fwdb),
    .mdu_busy        (mdu_busy),
    .stall_cycles    (stall_cycles)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       br;
    logic       exw;
    logic       exl;
    logic [4:0] exrn;
    logic       memw;
    logic       meml;
    logic [4:0] memrn;
    logic       e_wpcir;
    logic       e_bubble;
    logic       e_flush;
    logic [1:0] e_fwda;
    logic [1:0] e_fwdb;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_mdu_start = 0; id_use_hilo = 0; id_branch_taken = 0;
    ex_wreg = 0; ex_m2reg = 0; ex_rn = 0;
    mem_wreg = 0; mem_m2reg = 0; mem_rn = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    //        rs rt urs urt br exw exl exrn memw meml memrn | wpcir bub fl fa    fb
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 2'b00, 2'b00};
    vecs[1] = '{3, 3, 1, 1, 0, 1, 0, 3,  1, 0, 3,  1, 0, 0, 2'b01, 2'b01};
    vecs[2] = '{3, 3, 1, 1, 0, 1, 0, 0,  1, 0, 0,  1, 0, 0, 2'b00, 2'b00};
    vecs[3] = '{5, 0, 1, 1, 0, 0, 0, 0,  1, 0, 5,  1, 0, 0, 2'b10, 2'b00};
    vecs[4] = '{0, 7, 0, 1, 0, 0, 0, 0,  1, 1, 7,  1, 0, 0, 2'b00, 2'b11};
    vecs[5] = '{4, 0, 1, 0, 0, 0, 0, 4,  1, 0, 4,  1, 0, 0, 2'b10, 2'b00};
    vecs[6] = '{6, 6, 0, 0, 0, 1, 0, 6,  1, 0, 6,  1, 0, 0, 2'b00, 2'b00};
    vecs[7] = '{8, 0, 1, 0, 0, 1, 1, 8,  0, 0, 0,  0, 1, 0, 2'b00, 2'b00};
    vecs[8] = '{1, 2, 1, 1, 1, 0, 0, 0,  0, 0, 0,  1, 0, 1, 2'b00, 2'b00};
    vecs[9] = '{0, 9, 0, 1, 0, 1, 1, 9,  1, 0, 9,  0, 1, 0, 2'b00, 2'b10};

    clrn = 1'b0;
    idle_inputs();

    // Reset: forced outputs while low, even with a forwarding match present
    @(negedge clk);
    ex_wreg = 1; ex_rn = 3; id_rs = 3; id_use_rs = 1; id_rt = 3; id_use_rt = 1;
    #1;
    chk("rst_wpcir", wpcir, 1);
    chk("rst_bubble", id_bubble, 1);
    chk("rst_flush", if_flush, 1);
    chk("rst_fwda", fwda, 0);
    chk("rst_fwdb", fwdb, 0);
    @(negedge clk);
    idle_inputs();
    clrn = 1'b1;
    #1;
    chk("post_rst_wpcir", wpcir, 1);
    chk("post_rst_bubble", id_bubble, 0);
    chk("post_rst_flush", if_flush, 0);
    chk("post_rst_busy", mdu_busy, 0);
    chk("post_rst_stalls", stall_cycles, 0);

    // Table of combinational vectors (RUN state)
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
      id_branch_taken = vecs[i].br;
      ex_wreg = vecs[i].exw; ex_m2reg = vecs[i].exl; ex_rn = vecs[i].exrn;
      mem_wreg = vecs[i].memw; mem_m2reg = vecs[i].meml; mem_rn = vecs[i].memrn;
      #1;
      chk($sformatf("vec%0d_wpcir", i), wpcir, vecs[i].e_wpcir);
      chk($sformatf("vec%0d_bubble", i), id_bubble, vecs[i].e_bubble);
      chk($sformatf("vec%0d_flush", i), if_flush, vecs[i].e_flush);
      chk($sformatf("vec%0d_fwda", i), fwda, vecs[i].e_fwda);
      chk($sformatf("vec%0d_fwdb", i), fwdb, vecs[i].e_fwdb);
    end

    // Load-use: lw $8 in EX, add reading $8 in ID
    do_reset();
    @(negedge clk);
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 8; id_rs = 8; id_use_rs = 1;
    #1;
    chk("lu_wpcir", wpcir, 0);
    chk("lu_bubble", id_bubble, 1);
    @(negedge clk);
    ex_wreg = 0; ex_m2reg = 0; ex_rn = 0;
    mem_wreg = 1; mem_m2reg = 1; mem_rn = 8;
    #1;
    chk("lu_next_fwda", fwda, 2'b11);
    chk("lu_next_wpcir", wpcir, 1);
    chk("lu_stall_cnt", stall_cycles, 1);

    // MDU: mult at cycle 0, mflo in ID from cycle 1
    do_reset();
    @(negedge clk);
    id_mdu_start = 1; id_use_hilo = 1;
    #1;
    chk("mdu_c0_wpcir", wpcir, 1);
    chk("mdu_c0_busy", mdu_busy, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      id_mdu_start = 0; id_use_hilo = 1;
      #1;
      chk($sformatf("mdu_c%0d_wpcir", c), wpcir, 0);
      chk($sformatf("mdu_c%0d_bubble", c), id_bubble, 1);
      chk($sformatf("mdu_c%0d_busy", c), mdu_busy, 1);
    end
    @(negedge clk);
    #1;
    chk("mdu_c4_wpcir", wpcir, 1);
    chk("mdu_c4_busy", mdu_busy, 0);
    chk("mdu_stall_cnt", stall_cycles, 3);

    // MDU with an independent add following: no stall
    @(negedge clk);
    id_mdu_start = 1; id_use_hilo = 1;
    @(negedge clk);
    id_mdu_start = 0; id_use_hilo = 0; id_rs = 2; id_use_rs = 1;
    #1;
    chk("mdu_indep_wpcir", wpcir, 1);
    chk("mdu_indep_busy", mdu_busy, 1);

    // Branch taken alongside load-use: flush deferred one cycle
    do_reset();
    @(negedge clk);
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 5; id_rt = 5; id_use_rt = 1; id_branch_taken = 1;
    #1;
    chk("br_lu_flush", if_flush, 0);
    chk("br_lu_wpcir", wpcir, 0);
    @(negedge clk);
    ex_wreg = 0; ex_m2reg = 0; ex_rn = 0; mem_wreg = 1; mem_m2reg = 1; mem_rn = 5;
    #1;
    chk("br_next_flush", if_flush, 1);
    chk("br_next_wpcir", wpcir, 1);

    // Reset in MDU_WAIT with cnt = 2 abandons the wait
    do_reset();
    @(negedge clk);
    id_mdu_start = 1; id_use_hilo = 1;
    @(negedge clk);
    id_mdu_start = 0;
    @(negedge clk);
    #1;
    chk("rstw_busy_before", mdu_busy, 1);
    chk("rstw_stalls_before", stall_cycles, 1);
    clrn = 1'b0;
    #1;
    chk("rstw_low_wpcir", wpcir, 1);
    chk("rstw_low_bubble", id_bubble, 1);
    chk("rstw_low_flush", if_flush, 1);
    @(negedge clk);
    #1;
    chk("rstw_after_busy", mdu_busy, 0);
    chk("rstw_after_stalls", stall_cycles, 0);
    clrn = 1'b1;
    #1;
    chk("rstw_rel_wpcir", wpcir, 1);

    // Saturation of the stall counter
    do_reset();
    @(negedge clk);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 8; id_rs = 8; id_use_rs = 1;
    @(negedge clk);
    #1;
    chk("sat_reach", stall_cycles, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
